// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 key schedule constants, FSM encoding and byte-level helpers
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_KW = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EMIT0  = 3'd1,
    G_REQ  = 3'd2,
    G_WAIT = 3'd3,
    EXPAND = 3'd4,
    FINISH = 3'd5
  } key_state_t;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero for free.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_g_function.sv
// rtl/key_schedule_ctrl_g_function.sv - SubWord(RotWord()) unit with LAT-cycle done handshake
module g_function
  import aes_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] data_in,
  output logic        done,
  output logic [31:0] data_out
);

  logic [LAT-1:0] pend;

  // Result is registered on enable; the shift register only delays the done strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend     <= '0;
      data_out <= '0;
    end else begin
      pend <= LAT'({pend, enable});
      if (enable) data_out <= sub_rot_word(data_in);
    end
  end

  assign done = pend[LAT-1];

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128 key expansion sequencer streaming round keys 0..NR
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KW    = AES_KW,
  parameter int G_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          rk_valid,
  output logic [3:0]    rk_index,
  output logic [KW-1:0] rk_out,
  output logic          done
);

  key_state_t     state_q, state_d;
  logic [KW-1:0]  key_q;
  logic [KW-1:0]  next_key;
  logic [3:0]     round_q;
  logic [31:0]    t_q;
  logic [31:0]    t_rc;
  logic [31:0]    w0n, w1n, w2n, w3n;
  logic           g_enable;
  logic           g_done;
  logic [31:0]    g_data_out;
  logic           g_resetn;
  logic           last_round;

  assign g_resetn   = ~reset;
  assign last_round = (round_q == 4'(NR));

  g_function #(.LAT(G_LAT)) u_g_function (
    .clk      (clk),
    .resetn   (g_resetn),
    .enable   (g_enable),
    .data_in  (key_q[31:0]),
    .done     (g_done),
    .data_out (g_data_out)
  );

  assign t_rc     = t_q ^ {rcon(round_q), 24'h000000};
  assign w0n      = key_q[127:96] ^ t_rc;
  assign w1n      = key_q[95:64]  ^ w0n;
  assign w2n      = key_q[63:32]  ^ w1n;
  assign w3n      = key_q[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EMIT0;
      EMIT0:   state_d = G_REQ;
      G_REQ:   state_d = G_WAIT;
      G_WAIT:  if (g_done) state_d = EXPAND;
      EXPAND:  state_d = last_round ? FINISH : G_REQ;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    rk_valid = 1'b0;
    done     = 1'b0;
    g_enable = 1'b0;
    case (state_q)
      EMIT0: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
      end
      G_REQ: begin
        busy     = 1'b1;
        g_enable = 1'b1;
      end
      G_WAIT:  busy = 1'b1;
      EXPAND: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        done     = last_round;
      end
      default: ;
    endcase
  end

  // Key register doubles as the g_function operand and the held rk_out value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q   <= '0;
      round_q <= 4'd0;
      t_q     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          key_q   <= key_in;
          round_q <= 4'd0;
        end
        G_REQ:   round_q <= round_q + 4'd1;
        G_WAIT:  if (g_done) t_q <= g_data_out;
        EXPAND:  key_q <= next_key;
        default: ;
      endcase
    end
  end

  assign rk_out   = (state_q == EXPAND) ? next_key : key_q;
  assign rk_index = round_q;

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
- AES-128 key-expansion sequencer; sits directly downstream of g_function and consumes its output.
- Loads a 128-bit cipher key and iterates rounds 1..10. Each round it sends the previous round key's last word to g_function, applies Rcon, and XOR-chains the four words into the next round key.
- Streams round keys 0..10 to the cipher datapath, one valid pulse per key.

Parameters:
- NR, 10, number of expanded rounds; fixed for AES-128, other values unsupported.
- KW, 128, key/round-key width in bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle request to begin expansion of key_in
- key_in  input  128  cipher key; [127:96]=w0, [31:0]=w3; sampled only on accepted start
- busy  output  1  high from accepted start through the done cycle
- rk_valid  output  1  one-cycle pulse; rk_out/rk_index valid
- rk_index  output  4  round number of rk_out, 0..10
- rk_out  output  128  round key, same word order as key_in
- done  output  1  one-cycle pulse coincident with rk_valid of round 10

Behaviour:
- Reset values: busy=0, rk_valid=0, done=0, rk_index=0, rk_out=0, FSM=IDLE, round counter=0, g enable=0.
- g_function contract, decided for this block: pulse enable one cycle with data_in stable. done pulses once when data_out = SubWord(RotWord(data_in)). Latency L>=1 cycles, not fixed. The Rcon XOR is applied in this block, not in g_function.
- FSM states: IDLE, EMIT0, G_REQ, G_WAIT, EXPAND, FINISH.
- IDLE: start=1 -> latch key_in into key register, round=0, busy=1, go to EMIT0. start while busy is ignored, with no effect on the running expansion.
- EMIT0: rk_out=key, rk_index=0, rk_valid=1; next G_REQ. Round-0 key appears 1 cycle after start.
- G_REQ: g enable=1, g data_in=key[31:0]; round<=round+1; next G_WAIT.
- G_WAIT: hold data_in; on g done, capture g data_out into t; next EXPAND.
- EXPAND:
  - Compute t' = t ^ {RCON[round],24'h0}.
  - w0'=w0^t', w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Register the new key, drive rk_out, rk_index=round, rk_valid=1.
  - round<NR -> G_REQ; round==NR -> done=1 in the same cycle, next FINISH.
- FINISH: busy=0, all pulses low; next IDLE. A new start is accepted from IDLE only.
- Per-round latency from G_REQ to rk_valid = L+2 cycles. Total start -> done = 1 + NR*(L+2) cycles.
- A g done arriving outside G_WAIT is ignored.
- Reset mid-operation asynchronously returns to reset values. The first post-reset start performs a full, clean expansion.
- rk_out holds the last key between pulses; consumers sample only on rk_valid.

Decomposition:
- Shared package aes_pkg: RCON table (01,02,04,08,10,20,40,80,1B,36) indexed by round 1..10; NR/KW constants; the key_state_t enum for the FSM.
- One sub-module: the existing g_function, instantiated internally. Its clock comes from clk. Its active-low reset is driven by the inverted reset.
- XOR chain stays inline.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start -> rk_index 0 = key. Index 1 = a0fafe1788542cb123a339392a6c7605. Index 2 = f2c295f27a96b9435935807a7359f67f. Index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1.
- All-zero key -> index 1 = 62636363626363636263636362636363. Exactly 11 rk_valid pulses and 1 done pulse. busy drops the cycle after done.
- start re-pulsed at rounds 3 and 7 with a different key_in -> ignored; the sequence matches the first key's expected values.
- reset asserted in G_WAIT of round 5 -> outputs return to 0 asynchronously. A subsequent start with the FIPS key yields the full correct sequence from index 0.
- Back-to-back operation: start asserted the cycle after FINISH -> accepted, with the round-0 key one cycle later. Measured start->done equals 1+10*(L+2).
- g_function latency stretched via bind/force to L=3 -> identical round-key values; spacing of rk_valid pulses = 5 cycles.
